// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: byte-addressed big-endian instruction memory
// feeding a Q_DEPTH-entry bundle FIFO between fetch and decode.
module instruction_fetch_queue #(
    parameter int D_WIDTH   = 32,
    parameter int ISSUE     = 2,
    parameter int MEM_BYTES = 1024,
    parameter int Q_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [D_WIDTH-1:0]         i_wr_addr,
    input  logic [D_WIDTH-1:0]         i_wr_data,
    input  logic                       i_fetch_valid,
    input  logic [D_WIDTH-1:0]         i_fetch_addr,
    output logic                       o_fetch_ready,
    output logic                       o_valid,
    output logic [ISSUE*D_WIDTH-1:0]   o_instr,
    output logic [D_WIDTH-1:0]         o_pc,
    input  logic                       i_ready,
    input  logic                       i_flush
);
    localparam int A  = $clog2(MEM_BYTES);
    localparam int DB = D_WIDTH / 8;
    localparam int BW = ISSUE * D_WIDTH;
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = $clog2(Q_DEPTH + 1);

    logic [7:0]    r_mem     [MEM_BYTES];
    logic [BW-1:0] r_q_instr [Q_DEPTH];
    logic [A-1:0]  r_q_pc    [Q_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [BW-1:0] w_bundle;
    logic [A-1:0]  w_faddr;
    logic [A-1:0]  w_waddr;
    logic          w_unused;

    assign w_faddr  = i_fetch_addr[A-1:0];
    assign w_waddr  = i_wr_addr[A-1:0];
    assign w_unused = ^{i_wr_addr[D_WIDTH-1:A],
                        i_fetch_addr[D_WIDTH-1:A]};

    assign o_fetch_ready = rst_n && !i_flush
                        && (r_count < CW'(Q_DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_fetch_valid && o_fetch_ready;
    assign w_pop   = o_valid && i_ready && !i_flush;

    assign o_instr = o_valid ? r_q_instr[r_rd_ptr] : '0;
    assign o_pc    = o_valid ? D_WIDTH'(r_q_pc[r_rd_ptr]) : '0;

    // Gather ISSUE big-endian words starting at the fetch byte address.
    always_comb begin
        w_bundle = '0;
        for (int k = 0; k < ISSUE; k++) begin
            for (int j = 0; j < DB; j++) begin
                w_bundle[k*D_WIDTH + (DB-1-j)*8 +: 8] =
                    r_mem[w_faddr + A'(k*DB + j)];
            end
        end
    end

    // Program-load writes; reads see the pre-write bytes in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_n && i_wr_en) begin
            for (int j = 0; j < DB; j++) begin
                r_mem[w_waddr + A'(j)] <= i_wr_data[(DB-1-j)*8 +: 8];
            end
        end
    end

    // Capture the fetched bundle and its address at the queue tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= w_bundle;
            r_q_pc[r_wr_ptr]    <= w_faddr;
        end
    end

    // Queue pointers and occupancy; flush and reset empty the queue.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
